uc_multiciclo: RTL and testbench



---
 rtl/uc_multiciclo.sv | 135 +++++++++++++
 tb/tb_uc_multiciclo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo.sv
// rtl/uc_multiciclo.sv - multicycle FETCH/DECODE/EXEC control unit for the microc datapath
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Opcode[5:0]       opcode from the datapath IR (only [5:2] is decoded)
//   zero              registered Z flag from the datapath
//   s_inc, s_inm      PC mux (1 = PC+1) and register-write mux (1 = immediate)
//   we, wez           register-file and Z-flag write enables
//   ALUOp[2:0]        ALU operation, holds the last ALU value between ALU instructions
//   pc_en, ir_en      PC and IR load enables
//   halted            high while parked in HALT
//   illegal           sticky undefined-opcode flag
//   retired[CNT_W-1:0] instructions completed in EXEC (wraps)
module uc_multiciclo #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             ir_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [5:0]       opc_q;
    logic [2:0]       alu_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic [3:0] op;
    logic       is_alu;
    logic       is_halt;
    logic       is_illegal;
    logic       unused_opc_bits;

    // EXEC decodes the opcode captured in DECODE, so IR/Opcode glitches in EXEC are harmless.
    assign op              = opc_q[5:2];
    assign is_alu          = op[3];
    assign is_halt         = (op == 4'b0101);
    assign is_illegal      = (op == 4'b0110) || (op == 4'b0111);
    assign unused_opc_bits = ^opc_q[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            opc_q     <= 6'd0;
            alu_q     <= 3'd0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opc_q <= Opcode;
            end
            if (state_q == S_EXEC) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (is_alu) begin
                    alu_q <= op[2:0];
                end
                if (is_illegal) begin
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        s_inc   = 1'b1;
        s_inm   = 1'b0;
        we      = 1'b0;
        wez     = 1'b0;
        ALUOp   = alu_q;
        pc_en   = 1'b0;
        ir_en   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_en   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = is_halt ? S_HALT : S_FETCH;
                pc_en   = !is_halt;
                if (is_alu) begin
                    ALUOp = op[2:0];
                    we    = 1'b1;
                    wez   = 1'b1;
                end else begin
                    case (op)
                        4'b0000: begin
                            s_inm = 1'b1;
                            we    = 1'b1;
                        end
                        4'b0001: s_inc = 1'b0;
                        4'b0010: s_inc = ~zero;
                        4'b0011: s_inc = zero;
                        // NOP, HALT and the illegal codes write nothing.
                        default: ;
                    endcase
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb/tb_uc_multiciclo.sv - scoreboard testbench for uc_multiciclo
module tb_uc_multiciclo;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  Opcode = 6'd0;
    logic        zero = 1'b0;
    logic        s_inc, s_inm, we, wez, pc_en, ir_en, halted, illegal;
    logic [2:0]  ALUOp;
    logic [15:0] retired;

    uc_multiciclo #(.CNT_W(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .Opcode  (Opcode),
        .zero    (zero),
        .s_inc   (s_inc),
        .s_inm   (s_inm),
        .we      (we),
        .wez     (wez),
        .ALUOp   (ALUOp),
        .pc_en   (pc_en),
        .ir_en   (ir_en),
        .halted  (halted),
        .illegal (illegal),
        .retired (retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [26:0] exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passes = 0;

    // Bench-side record of the sticky/held outputs, set from hand-written call arguments.
    logic [2:0]  m_alu = 3'd0;
    logic        m_ill = 1'b0;
    logic [15:0] m_ret = 16'd0;

    function automatic logic [26:0] pk(input logic i_s_inc, input logic i_s_inm,
                                       input logic i_we, input logic i_wez,
                                       input logic [2:0] i_alu, input logic i_pc_en,
                                       input logic i_ir_en, input logic i_halted,
                                       input logic i_ill, input logic [15:0] i_ret);
        return {i_s_inc, i_s_inm, i_we, i_wez, i_alu, i_pc_en, i_ir_en, i_halted, i_ill, i_ret};
    endfunction

    task automatic push(input string nm, input logic [26:0] e);
        exp_t t;
        t.cyc  = cyc;
        t.name = nm;
        t.exp  = e;
        q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
    initial begin
        logic [26:0] act;
        exp_t        t;
        forever begin
            @(negedge clk);
            act = {s_inc, s_inm, we, wez, ALUOp, pc_en, ir_en, halted, illegal, retired};
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                t = q.pop_front();
                checks++;
                if (t.cyc < cyc) begin
                    $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", t.name, t.cyc, cyc);
                end else if (act !== t.exp) begin
                    $display("FAIL %s: got ctl=%b alu=%b en=%b hlt=%b ill=%b ret=%0d, want ctl=%b alu=%b en=%b hlt=%b ill=%b ret=%0d",
                             t.name, act[26:23], act[22:20], act[19:18], act[17], act[16], act[15:0],
                             t.exp[26:23], t.exp[22:20], t.exp[19:18], t.exp[17], t.exp[16], t.exp[15:0]);
                end else begin
                    passes++;
                end
            end
        end
    end

    // One full instruction starting in its FETCH cycle; ends in the following cycle.
    task automatic run_instr(input string nm, input logic [5:0] opc, input logic [5:0] exec_opc,
                             input logic z, input logic e_s_inc, input logic e_s_inm,
                             input logic e_we, input logic e_wez, input logic [2:0] e_alu,
                             input logic e_pc, input logic [2:0] n_alu, input logic n_ill,
                             input logic [15:0] n_ret);
        Opcode = opc;
        zero   = z;
        push({nm, "_fetch"}, pk(1'b1, 1'b0, 1'b0, 1'b0, m_alu, 1'b0, 1'b1, 1'b0, m_ill, m_ret));
        step();
        push({nm, "_decode"}, pk(1'b1, 1'b0, 1'b0, 1'b0, m_alu, 1'b0, 1'b0, 1'b0, m_ill, m_ret));
        step();
        Opcode = exec_opc;
        push({nm, "_exec"}, pk(e_s_inc, e_s_inm, e_we, e_wez, e_alu, e_pc, 1'b0, 1'b0, m_ill, m_ret));
        step();
        m_alu = n_alu;
        m_ill = n_ill;
        m_ret = n_ret;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        step();
        push("reset_state", pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
        step();
        reset = 1'b0;

        //        name     opc        exec_opc   z     inc   inm   we    wez   alu     pc    n_alu   n_ill n_ret
        run_instr("li",    6'b000000, 6'b000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0,   1'b1, 3'd0,   1'b0, 16'd1);
        run_instr("alu3",  6'b101100, 6'b101100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 1'b1, 3'b011, 1'b0, 16'd2);
        run_instr("jnz_z0",6'b001100, 6'b001100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 3'b011, 1'b0, 16'd3);
        run_instr("jnz_z1",6'b001100, 6'b001100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 3'b011, 1'b0, 16'd4);
        run_instr("jz_z1", 6'b001010, 6'b001010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 3'b011, 1'b0, 16'd5);
        run_instr("jmp",   6'b000111, 6'b000111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 3'b011, 1'b0, 16'd6);
        run_instr("alu6",  6'b111001, 6'b111001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 1'b1, 3'b110, 1'b0, 16'd7);
        run_instr("illeg", 6'b011000, 6'b011000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 3'b110, 1'b1, 16'd8);
        run_instr("nop",   6'b010000, 6'b010000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b1, 3'b110, 1'b1, 16'd9);
        run_instr("halt",  6'b010100, 6'b010100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 3'b110, 1'b1, 16'd10);

        for (int i = 0; i < 11; i++) begin
            Opcode = 6'b100000 | 6'(i);
            push($sformatf("halt_hold%0d", i), pk(1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 16'd10));
            step();
        end

        reset = 1'b1;
        push("halt_reset", pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
        step();
        reset = 1'b0;
        m_alu = 3'd0;
        m_ill = 1'b0;
        m_ret = 16'd0;

        // Reset pulse inside an ALU EXEC: enables must drop in that same cycle.
        Opcode = 6'b100100;
        push("mid_fetch", pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
        step();
        push("mid_decode", pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0));
        step();
        reset = 1'b1;
        push("mid_exec_reset", pk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
        step();
        reset = 1'b0;

        // Opcode flips to HALT during EXEC; decode must still follow the latched ALU op.
        run_instr("bogus", 6'b100100, 6'b010100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 1'b1, 3'b001, 1'b0, 16'd1);
        push("after_bogus", pk(1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1));
        step();
        step();

        if (q.size() != 0) begin
            checks++;
            $display("FAIL pending: %0d expectations left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
